// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO read-side drain logic.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_WIDTH = 8;
    localparam int unsigned BUF_DEPTH       = 2;
    localparam int unsigned RD_CNT_WIDTH    = 16;
    localparam int unsigned OCC_WIDTH       = $clog2(BUF_DEPTH + 1);

    typedef logic [OCC_WIDTH-1:0] occ_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry output buffer with 1-bit wrapping read/write pointers.
// head always presents the oldest stored word straight from the storage registers.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output occ_t                  occ,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    occ_t                  occ_q, occ_d;

    // Next-state for pointers and occupancy; a push and pop together leave occ unchanged.
    always_comb begin
        wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
        occ_d    = occ_q;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + occ_t'(1);
            2'b01:   occ_d = occ_q - occ_t'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Storage and pointer registers; reset clears the words so head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign occ   = occ_q;
    assign head  = mem_q[rd_ptr_q];
    assign full  = (occ_q == occ_t'(BUF_DEPTH));
    assign empty = (occ_q == '0);

endmodule

// File: rtl/fifo_reader.sv
// Drains a synchronous FIFO read port into a valid/ready output stream.
// Issues reads, tracks the one-cycle in-flight word and captures it into a
// two-entry buffer. Optional delivered-word counter rd_cnt when FIFO_READER_CNT_EN
// is defined; without it the port and counter do not exist.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    input  logic                    out_ready
`ifdef FIFO_READER_CNT_EN
    ,
    output logic [RD_CNT_WIDTH-1:0] rd_cnt
`endif
);

    logic infl_q, infl_d;
    logic pop;
    logic buf_full, buf_empty;
    occ_t buf_occ;

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (infl_q),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .occ       (buf_occ),
        .head      (out_data),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign out_valid = ~buf_empty;
    assign pop       = out_valid & out_ready;

    // Read whenever a slot will be free after this edge: a pop always frees one,
    // otherwise committed words (occ + infl) must be below two. Since occ = 2
    // implies no word is in flight, "full" or "one stored plus one in flight"
    // are the only no-room cases. rst_n gates the strobe so no read is issued
    // while the block is held in reset.
    always_comb begin
        fifo_rd_en = rst_n & ~fifo_empty &
                     (pop | (~buf_full & ~((buf_occ == occ_t'(1)) & infl_q)));
        infl_d     = fifo_rd_en;
    end

    // In-flight flag: the FIFO word read at this edge is captured at the next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_q <= 1'b0;
        end else begin
            infl_q <= infl_d;
        end
    end

`ifdef FIFO_READER_CNT_EN
    logic [RD_CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;

    assign rd_cnt_d = pop ? rd_cnt_q + RD_CNT_WIDTH'(1) : rd_cnt_q;

    // Delivered-word counter, wraps naturally at its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign rd_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a 16-deep byte FIFO model feeds the DUT; the expected
// stream is the order of words written, and the expected read strobe / valid
// follow from how many words have left the FIFO but not yet been delivered.
module tb_fifo_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fifo_empty = 1'b1;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
`ifdef FIFO_READER_CNT_EN
    logic [15:0] rd_cnt;
    logic [15:0] cnt_tb = 16'h0;
`endif

    always #5 clk = ~clk;

    fifo_reader #(.DATA_WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready)
`ifdef FIFO_READER_CNT_EN
        ,
        .rd_cnt       (rd_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;

    byte unsigned fifo_q[$];
    byte unsigned exp_q[$];
    byte unsigned dlog[$];
    bit           rlog[$];
    bit           vlog[$];
    bit           infl_tb = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fifo_write(input byte unsigned w);
        if (fifo_q.size() < 16) begin
            fifo_q.push_back(w);
            exp_q.push_back(w);
            fifo_empty = 1'b0;
        end
    endtask

    // One clock: check against the model mid-cycle, then advance to edge+1
    // where the FIFO model delivers the word read at that edge.
    task automatic cycle();
        int held;
        bit exp_valid;
        bit exp_rd;
        bit pop;
        bit rd_seen;
        #3;
        held      = exp_q.size() - fifo_q.size();
        exp_valid = (held - int'(infl_tb)) > 0;
        pop       = exp_valid && (out_ready === 1'b1);
        exp_rd    = (fifo_q.size() != 0) && ((held - int'(pop)) < 2);
        chk("out_valid", out_valid, exp_valid);
        if (exp_valid) chk("out_data", out_data, exp_q[0]);
        chk("fifo_rd_en", fifo_rd_en, exp_rd);
`ifdef FIFO_READER_CNT_EN
        chk("rd_cnt", rd_cnt, cnt_tb);
`endif
        rlog.push_back(fifo_rd_en === 1'b1);
        vlog.push_back(out_valid === 1'b1);
        if (pop) begin
            dlog.push_back(exp_q.pop_front());
`ifdef FIFO_READER_CNT_EN
            cnt_tb = cnt_tb + 16'd1;
`endif
        end
        rd_seen = (fifo_rd_en === 1'b1) && (fifo_q.size() != 0);
        infl_tb = rd_seen;
        @(posedge clk);
        #1;
        if (rd_seen) fifo_rd_data = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic clear_logs();
        rlog.delete();
        vlog.delete();
        dlog.delete();
    endtask

    function automatic int count_ones(input bit q[$]);
        int n = 0;
        foreach (q[i]) if (q[i]) n++;
        return n;
    endfunction

    initial begin
        int f;
        int run;
        int n;

        // Power-on reset
        #2;
        chk("rst_rd_en", fifo_rd_en, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Stream 0..9 with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) fifo_write(8'(i));
        clear_logs();
        repeat (14) cycle();
        chk("stream_first_rd", rlog[0], 1'b1);
        f = -1;
        for (int i = 0; i < vlog.size(); i++) if (vlog[i] && f < 0) f = i;
        chk("stream_latency", f, 2);
        run = 0;
        for (int i = 2; i < vlog.size() && vlog[i]; i++) run++;
        chk("stream_b2b", run, 10);
        chk("stream_count", dlog.size(), 10);
        for (int i = 0; i < 10 && i < dlog.size(); i++) chk("stream_order", dlog[i], i);
`ifdef FIFO_READER_CNT_EN
        chk("stream_rd_cnt", rd_cnt, 16'd10);
`endif

        // Backpressure: 3,4,5 with out_ready low
        out_ready = 1'b0;
        fifo_write(8'd3);
        fifo_write(8'd4);
        fifo_write(8'd5);
        clear_logs();
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (i >= 2) begin
                chk("bp_valid", out_valid, 1'b1);
                chk("bp_hold", out_data, 8'd3);
            end
        end
        chk("bp_reads", count_ones(rlog), 2);
        out_ready = 1'b1;
        clear_logs();
        repeat (6) cycle();
        chk("bp_extra_reads", count_ones(rlog), 1);
        chk("bp_count", dlog.size(), 3);
        for (int i = 0; i < 3 && i < dlog.size(); i++) chk("bp_order", dlog[i], 3 + i);

        // Empty guard: single word 88
        clear_logs();
        fifo_write(8'd88);
        repeat (6) cycle();
        chk("eg_first_rd", rlog[0], 1'b1);
        chk("eg_reads", count_ones(rlog), 1);
        chk("eg_count", dlog.size(), 1);
        if (dlog.size() > 0) chk("eg_word", dlog[0], 8'd88);

        // Simultaneous capture and pop: 33 written every cycle
        clear_logs();
        for (int i = 0; i < 12; i++) begin
            fifo_write(8'd33);
            cycle();
            if (i >= 2) begin
                chk("sim_valid", vlog[i], 1'b1);
                chk("sim_rd", rlog[i], 1'b1);
            end
        end
        chk("sim_count", dlog.size(), 10);
        foreach (dlog[i]) chk("sim_word", dlog[i], 8'd33);
        repeat (4) cycle();

        // Reset mid-stream with two words buffered
        out_ready = 1'b0;
        fifo_write(8'h50);
        fifo_write(8'h51);
        fifo_write(8'h52);
        repeat (4) cycle();
        chk("pre_rst_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mrst_rd_en", fifo_rd_en, 1'b0);
        chk("mrst_valid", out_valid, 1'b0);
        chk("mrst_data", out_data, 8'h00);
`ifdef FIFO_READER_CNT_EN
        chk("mrst_rd_cnt", rd_cnt, 16'd0);
        cnt_tb = 16'h0;
`endif
        n = exp_q.size() - fifo_q.size();
        repeat (n) void'(exp_q.pop_front());
        infl_tb = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_hold_rd_en", fifo_rd_en, 1'b0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        clear_logs();
        repeat (6) cycle();
        chk("mrst_count", dlog.size(), 1);
        if (dlog.size() > 0) chk("mrst_first", dlog[0], 8'h52);

        // Randomised traffic and backpressure
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 1) fifo_write(8'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        out_ready = 1'b1;
        repeat (20) cycle();
        chk("drain_valid", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
